eth_phy_rx_block_lock_ml: RTL
=============================

ETH_PHY_RX_BLOCK_LOCK_ML -- requirements
Module: eth_phy_rx_block_lock_ml

Interface
REQ-001 SHALL have parameter LANES, default 1, number of independent 64b/66b lanes (1..4).
REQ-002 SHALL have parameter HDR_WIDTH, default 2, sync header width; only value 2 is legal.
REQ-003 SHALL have parameter SH_WINDOW, default 64, headers per test window (power of two, 8..1024).
REQ-004 SHALL have parameter INVALID_LIMIT, default 16, invalid headers per window that drop lock (1..SH_WINDOW-1).
REQ-005 SHALL have parameter BITSLIP_HIGH_CYCLES, default 1, bitslip pulse length in cycles (>=1).
REQ-006 SHALL have parameter BITSLIP_LOW_CYCLES, default 8, post-pulse cycles during which headers are ignored (>=0).
REQ-007 SHALL have port rx_clk, input, 1, the single clock; all logic on its rising edge.
REQ-008 SHALL have port rx_rst, input, 1, reset; synchronous, active-high.
REQ-009 SHALL have port serdes_rx_hdr, input, LANES*HDR_WIDTH, lane n header at bits [2n+1:2n].
REQ-010 SHALL have port serdes_rx_hdr_valid, input, LANES, per-lane qualifier; headers are sampled only when it is 1.
REQ-011 SHALL have port cfg_clear_count, input, 1, synchronous clear of all lock-loss counters.
REQ-012 SHALL have port serdes_rx_bitslip, output, LANES, per-lane bitslip request.
REQ-013 SHALL have port rx_block_lock, output, LANES, per-lane lock status.
REQ-014 SHALL have port rx_all_locked, output, 1, AND of all rx_block_lock bits.
REQ-015 SHALL have port rx_lock_loss_count, output, LANES*8, lane n saturating lock-loss count at bits [8n+7:8n].

Function
REQ-016 A header SHALL be valid when equal to 2'b01 or 2'b10; 2'b00 and 2'b11 SHALL be invalid.
REQ-017 Each lane SHALL run an FSM with states UNLOCKED, LOCKED, SLIP_WAIT; all counters SHALL advance only on cycles with hdr_valid=1 and state != SLIP_WAIT.
REQ-018 Each lane SHALL keep sh_count (0..SH_WINDOW-1) and sh_invalid_count (0..INVALID_LIMIT); both SHALL clear at window end, slip entry and reset.
REQ-019 UNLOCKED: an invalid sampled header SHALL enter SLIP_WAIT; SH_WINDOW consecutive valid samples SHALL enter LOCKED.
REQ-020 LOCKED: the INVALID_LIMIT-th invalid header within one window SHALL enter SLIP_WAIT; a window completing with fewer SHALL stay LOCKED and restart counting.
REQ-021 If the INVALID_LIMIT-th invalid header coincides with the last header of the window, lock loss SHALL take priority.
REQ-022 SLIP_WAIT: serdes_rx_bitslip SHALL be 1 for exactly BITSLIP_HIGH_CYCLES cycles, then 0 for BITSLIP_LOW_CYCLES cycles, then the lane SHALL return to UNLOCKED; headers in SLIP_WAIT SHALL be ignored.
REQ-023 All outputs SHALL be registered; rx_block_lock SHALL change in the cycle after the deciding header is sampled; bitslip rises in the same cycle.
REQ-024 rx_block_lock SHALL be 1 exactly while the lane is LOCKED.
REQ-025 rx_lock_loss_count[n] SHALL increment on each LOCKED->SLIP_WAIT transition of lane n, saturating at 255; UNLOCKED->SLIP_WAIT SHALL not count.
REQ-026 cfg_clear_count coinciding with a loss event SHALL clear the count to 0 (clear wins).
REQ-027 Lanes SHALL be fully independent; activity on one lane SHALL not affect another.

Reset
REQ-028 rx_rst=1 SHALL put every lane in UNLOCKED with all counters 0, serdes_rx_bitslip=0, rx_block_lock=0, rx_all_locked=0, rx_lock_loss_count=0, overriding all other inputs, including mid-slip.

Structure
REQ-029 Header encodings (2'b01 data, 2'b10 control), FSM state encoding and counter width 8 SHALL live in shared package eth_phy_pkg.
REQ-030 Per-lane logic SHALL be sub-module eth_phy_rx_block_lock_lane, instantiated LANES times by generate; top adds only rx_all_locked.

Verification
REQ-031 Defaults, LANES=1, hdr 2'b10 valid every cycle from reset release -> rx_block_lock=1 after the 64th sample, bitslip never asserted.
REQ-032 Locked, then per window 62 valid + 1 invalid + 1 valid, repeated 3 windows -> lock held, loss count 0.
REQ-033 Locked, then 16 consecutive 2'b00 -> lock drops one cycle after the 16th, bitslip high 1 cycle, low 8, loss count 1; 15 consecutive 2'b00 -> lock held.
REQ-034 Unlocked, single 2'b11 at sample 30 -> immediate slip, counters restart, lock only after 64 further valid samples.
REQ-035 LANES=4, lane 2 fed 2'b00, others 2'b01 -> rx_block_lock=4'b1011, rx_all_locked=0, lane 2 bitslips periodically every 9 cycles.
REQ-036 Assert rx_rst during bitslip high, and cfg_clear_count with a loss event -> all outputs 0 next cycle; count reads 0.

Source files
------------

// File: rtl/eth_phy_pkg.sv
// Shared definitions for the 64b/66b receive block-lock logic:
// sync header encodings, lane FSM states and the lock-loss counter width.
package eth_phy_pkg;

  localparam logic [1:0] SYNC_DATA = 2'b01;
  localparam logic [1:0] SYNC_CTRL = 2'b10;
  localparam int         CNT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_UNLOCKED  = 2'd0,
    ST_LOCKED    = 2'd1,
    ST_SLIP_WAIT = 2'd2
  } lock_state_t;

  // Only the two mixed-bit patterns are legal 64b/66b sync headers.
  function automatic logic hdr_is_valid(input logic [1:0] hdr);
    return (hdr == SYNC_DATA) || (hdr == SYNC_CTRL);
  endfunction

endpackage

// File: rtl/eth_phy_rx_block_lock_lane.sv
// Block-lock state machine for one 64b/66b lane: hunts for sync-header
// alignment, monitors the locked stream and issues bitslip requests.
module eth_phy_rx_block_lock_lane
  import eth_phy_pkg::*;
#(
  parameter int SH_WINDOW           = 64,
  parameter int INVALID_LIMIT       = 16,
  parameter int BITSLIP_HIGH_CYCLES = 1,
  parameter int BITSLIP_LOW_CYCLES  = 8
) (
  input  logic                 clk,
  input  logic                 srst,
  input  logic [1:0]           hdr,
  input  logic                 hdr_valid,
  input  logic                 clear_count,
  output logic                 bitslip,
  output logic                 block_lock,
  output logic                 block_lock_next,
  output logic [CNT_WIDTH-1:0] lock_loss_count
);

  // The UNLOCKED cycle that follows SLIP_WAIT closes the low phase, so the
  // wait state itself only covers HIGH+LOW-1 cycles. A lane fed garbage
  // therefore slips once every HIGH+LOW cycles.
  localparam int SLIP_CYCLES = (BITSLIP_LOW_CYCLES == 0) ? BITSLIP_HIGH_CYCLES
                             : BITSLIP_HIGH_CYCLES + BITSLIP_LOW_CYCLES - 1;
  localparam int SH_W   = $clog2(SH_WINDOW);
  localparam int INV_W  = $clog2(INVALID_LIMIT + 1);
  localparam int SLIP_W = $clog2(SLIP_CYCLES + 1);

  localparam logic [SH_W-1:0]   SH_LAST   = SH_W'(SH_WINDOW - 1);
  localparam logic [INV_W-1:0]  INV_LAST  = INV_W'(INVALID_LIMIT - 1);
  localparam logic [SLIP_W-1:0] SLIP_LAST = SLIP_W'(SLIP_CYCLES - 1);
  localparam logic [SLIP_W-1:0] SLIP_HIGH = SLIP_W'(BITSLIP_HIGH_CYCLES);

  lock_state_t          state_reg, state_next;
  logic [SH_W-1:0]      sh_count_reg, sh_count_next;
  logic [INV_W-1:0]     inv_count_reg, inv_count_next;
  logic [SLIP_W-1:0]    slip_count_reg, slip_count_next;
  logic [CNT_WIDTH-1:0] loss_count_reg, loss_count_next;
  logic                 bitslip_reg, bitslip_next;
  logic                 lock_reg;
  logic                 hdr_ok;
  logic                 enter_slip;
  logic                 count_loss;

  // Next-state, counter and output decode for the lane FSM.
  always_comb begin
    state_next      = state_reg;
    sh_count_next   = sh_count_reg;
    inv_count_next  = inv_count_reg;
    slip_count_next = slip_count_reg;
    loss_count_next = loss_count_reg;
    bitslip_next    = 1'b0;
    enter_slip      = 1'b0;
    count_loss      = 1'b0;
    hdr_ok          = hdr_is_valid(hdr);

    case (state_reg)
      ST_UNLOCKED: begin
        if (hdr_valid) begin
          if (!hdr_ok) begin
            enter_slip = 1'b1;
          end else if (sh_count_reg == SH_LAST) begin
            state_next     = ST_LOCKED;
            sh_count_next  = '0;
            inv_count_next = '0;
          end else begin
            sh_count_next = sh_count_reg + 1'b1;
          end
        end
      end
      ST_LOCKED: begin
        if (hdr_valid) begin
          // Reaching the invalid limit beats a simultaneous window end.
          if (!hdr_ok && (inv_count_reg == INV_LAST)) begin
            enter_slip = 1'b1;
            count_loss = 1'b1;
          end else if (sh_count_reg == SH_LAST) begin
            sh_count_next  = '0;
            inv_count_next = '0;
          end else begin
            sh_count_next = sh_count_reg + 1'b1;
            if (!hdr_ok) begin
              inv_count_next = inv_count_reg + 1'b1;
            end
          end
        end
      end
      ST_SLIP_WAIT: begin
        if (slip_count_reg == SLIP_LAST) begin
          state_next      = ST_UNLOCKED;
          slip_count_next = '0;
        end else begin
          slip_count_next = slip_count_reg + 1'b1;
          bitslip_next    = (slip_count_next < SLIP_HIGH);
        end
      end
      default: begin
        state_next = ST_UNLOCKED;
      end
    endcase

    if (enter_slip) begin
      state_next      = ST_SLIP_WAIT;
      sh_count_next   = '0;
      inv_count_next  = '0;
      slip_count_next = '0;
      bitslip_next    = 1'b1;
    end

    if (clear_count) begin
      loss_count_next = '0;
    end else if (count_loss && (loss_count_reg != '1)) begin
      loss_count_next = loss_count_reg + 1'b1;
    end
  end

  assign block_lock_next = (state_next == ST_LOCKED);

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (srst) begin
      state_reg      <= ST_UNLOCKED;
      sh_count_reg   <= '0;
      inv_count_reg  <= '0;
      slip_count_reg <= '0;
      loss_count_reg <= '0;
      bitslip_reg    <= 1'b0;
      lock_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      sh_count_reg   <= sh_count_next;
      inv_count_reg  <= inv_count_next;
      slip_count_reg <= slip_count_next;
      loss_count_reg <= loss_count_next;
      bitslip_reg    <= bitslip_next;
      lock_reg       <= block_lock_next;
    end
  end

  assign bitslip         = bitslip_reg;
  assign block_lock      = lock_reg;
  assign lock_loss_count = loss_count_reg;

endmodule

// File: rtl/eth_phy_rx_block_lock_ml.sv
// Multi-lane 64b/66b receive block lock: one independent lock FSM per lane
// plus a registered all-lanes-locked summary.
module eth_phy_rx_block_lock_ml
  import eth_phy_pkg::*;
#(
  parameter int LANES               = 1,
  parameter int HDR_WIDTH           = 2,
  parameter int SH_WINDOW           = 64,
  parameter int INVALID_LIMIT       = 16,
  parameter int BITSLIP_HIGH_CYCLES = 1,
  parameter int BITSLIP_LOW_CYCLES  = 8
) (
  input  logic                         rx_clk,
  input  logic                         rx_rst,
  input  logic [LANES*HDR_WIDTH-1:0]   serdes_rx_hdr,
  input  logic [LANES-1:0]             serdes_rx_hdr_valid,
  input  logic                         cfg_clear_count,
  output logic [LANES-1:0]             serdes_rx_bitslip,
  output logic [LANES-1:0]             rx_block_lock,
  output logic                         rx_all_locked,
  output logic [LANES*CNT_WIDTH-1:0]   rx_lock_loss_count
);

  logic [LANES-1:0] lock_next;
  logic             all_locked_reg;

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    eth_phy_rx_block_lock_lane #(
      .SH_WINDOW           (SH_WINDOW),
      .INVALID_LIMIT       (INVALID_LIMIT),
      .BITSLIP_HIGH_CYCLES (BITSLIP_HIGH_CYCLES),
      .BITSLIP_LOW_CYCLES  (BITSLIP_LOW_CYCLES)
    ) u_lane (
      .clk             (rx_clk),
      .srst            (rx_rst),
      .hdr             (serdes_rx_hdr[gi*HDR_WIDTH +: 2]),
      .hdr_valid       (serdes_rx_hdr_valid[gi]),
      .clear_count     (cfg_clear_count),
      .bitslip         (serdes_rx_bitslip[gi]),
      .block_lock      (rx_block_lock[gi]),
      .block_lock_next (lock_next[gi]),
      .lock_loss_count (rx_lock_loss_count[gi*CNT_WIDTH +: CNT_WIDTH])
    );
  end

  // Summary flag built from the lanes' next lock state so it moves in the
  // same cycle as the per-lane lock bits.
  always_ff @(posedge rx_clk) begin
    if (rx_rst) begin
      all_locked_reg <= 1'b0;
    end else begin
      all_locked_reg <= &lock_next;
    end
  end

  assign rx_all_locked = all_locked_reg;

endmodule
